// File: rtl/and_gate_unit.sv
// Registered bitwise-AND slice of the integer ALU with zero/negative status flags.
// One accepted operand pair per cycle, result and flags visible one clock later.
module and_gate_unit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             zero,
    output logic             negative
);

    logic [WIDTH-1:0] w_and;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_negative;
    logic             r_out_valid;

    assign w_and = A & B;

    // Data flops only load on accept, so operand values seen while idle never reach the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_result    <= '0;
            r_zero      <= 1'b1;
            r_negative  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_result   <= w_and;
                r_zero     <= ~(|w_and);
                r_negative <= w_and[WIDTH-1];
            end
        end
    end

    assign result    = r_result;
    assign zero      = r_zero;
    assign negative  = r_negative;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_and_gate_unit.sv
// Self-checking bench for and_gate_unit: a reference model pushes expected outputs
// into a scoreboard queue as stimulus is driven; each cycle's DUT outputs are popped and compared.
module tb_and_gate_unit;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] res;
        logic         z;
        logic         n;
        logic         v;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] result;
    logic         out_valid;
    logic         zero;
    logic         negative;

    int checks;
    int errors;

    exp_t         sb_q[$];
    logic [W-1:0] m_res;
    logic         m_z;
    logic         m_n;
    logic         m_v;

    and_gate_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .A        (A),
        .B        (B),
        .result   (result),
        .out_valid(out_valid),
        .zero     (zero),
        .negative (negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle on the falling edge, predict, then compare just after the rising edge.
    task automatic cycle(input logic r, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        exp_t got;
        @(negedge clk);
        rst      = r;
        in_valid = v;
        A        = a;
        B        = b;
        if (r) begin
            m_res = '0; m_z = 1'b1; m_n = 1'b0; m_v = 1'b0;
        end else if (v) begin
            m_res = a & b;
            m_z   = ((a & b) == '0);
            m_n   = a[W-1] & b[W-1];
            m_v   = 1'b1;
        end else begin
            m_v = 1'b0;
        end
        e.res = m_res; e.z = m_z; e.n = m_n; e.v = m_v;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
        end else begin
            got = sb_q.pop_front();
            check_eq("result",    {28'd0, result}, {28'd0, got.res});
            check_eq("zero",      {31'd0, zero},   {31'd0, got.z});
            check_eq("negative",  {31'd0, negative}, {31'd0, got.n});
            check_eq("out_valid", {31'd0, out_valid}, {31'd0, got.v});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0;
        m_res = '0; m_z = 1'b1; m_n = 1'b0; m_v = 1'b0;

        // Reset held two cycles with a valid all-ones pair that must be discarded
        cycle(1'b1, 1'b1, 4'b1111, 4'b1111);
        cycle(1'b1, 1'b1, 4'b1111, 4'b1111);
        check_eq("reset_result", {28'd0, result}, 32'h0);
        check_eq("reset_zero",   {31'd0, zero},   32'h1);

        cycle(1'b0, 1'b1, 4'b1010, 4'b1011);
        check_eq("basic_result", {28'd0, result}, 32'hA);
        check_eq("basic_neg",    {31'd0, negative}, 32'h1);

        cycle(1'b0, 1'b1, 4'b0000, 4'b1111);
        cycle(1'b0, 1'b1, 4'b0101, 4'b1010);
        check_eq("disjoint_zero", {31'd0, zero}, 32'h1);

        // Hold: idle cycles with wandering operands must not disturb the registered value
        cycle(1'b0, 1'b1, 4'b1100, 4'b0110);
        for (int i = 0; i < 10; i++)
            cycle(1'b0, 1'b0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        check_eq("hold_result", {28'd0, result}, 32'h4);

        cycle(1'b0, 1'b1, 4'b1111, 4'b1111);
        cycle(1'b0, 1'b1, 4'b1000, 4'b1001);
        cycle(1'b0, 1'b1, 4'b0011, 4'b0111);
        cycle(1'b0, 1'b1, 4'b0000, 4'b0000);

        // Reset mid-stream, then recovery on the very next valid pair
        cycle(1'b0, 1'b1, 4'b1110, 4'b0111);
        cycle(1'b1, 1'b1, 4'b1111, 4'b1111);
        cycle(1'b0, 1'b1, 4'b1001, 4'b1101);
        check_eq("recover_result", {28'd0, result}, 32'h9);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                cycle(1'b0, 1'b1, 4'(a), 4'(b));

        cycle(1'b0, 1'b0, 4'b0000, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
